uart_rx_oversample: RTL and testbench

- 8N1 UART receiver, one stage downstream of the 16x baud clock divider.
- Runs entirely on the 100 MHz system clock clk. Treats the divider's 153.6 kHz output (16 x 9600 baud) as a sample-enable, not as a clock.
- Synchronises the serial line and detects the start bit. Samples each bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe and reports framing errors.

---
 rtl/uart_rx_oversample.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver running on the system clock.
// The divider's oversample clock is used as a sample enable, not as a clock.
// The serial line and os_clk are both brought in through 2-FF synchronisers.
// The start bit is confirmed at mid-bit. Every later bit is sampled
// OVERSAMPLE ticks after the previous sample.
`timescale 1ns/1ps
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16   // even, >= 4
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 os_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    // Synchroniser and edge-detect flops
    logic rx_meta, rx_s;
    logic os_meta, os_s, os_d;
    logic tick;

    // Frame state
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     os_cnt_q, os_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 fe_q, fe_d;

    // rx idles high, so its synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Synchronise os_clk and register its rising edge as a one-clk tick.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            os_meta <= 1'b0;
            os_s    <= 1'b0;
            os_d    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            os_meta <= os_clk;
            os_s    <= os_meta;
            os_d    <= os_s;
            tick    <= os_s & ~os_d;
        end
    end

    // State, counters, shift register and output pulse registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    // Next state: progress only on ticks. The pulses default low, so each
    // pulse is exactly one clk wide however slow the oversample rate is.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d  = START;
                        os_cnt_d = '0;
                    end
                end

                START: begin
                    if (os_cnt_q == CNT_MID) begin
                        os_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end else begin
                            // Line went back high before mid-bit: this was a
                            // glitch, not a start bit.
                            state_d = IDLE;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (os_cnt_q == CNT_LAST) begin
                        os_cnt_d = '0;
                        // LSB arrives first, so shift in from the MSB side.
                        shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (os_cnt_q == CNT_LAST) begin
                        os_cnt_d = '0;
                        if (rx_s) begin
                            data_d  = shreg_q;
                            dv_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + CNT_W'(1);
                    end
                end

                BREAK: begin
                    // Wait for the line to return high, so a held-low line
                    // reports one error rather than a stream of them.
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign data          = data_q;
    assign data_valid    = dv_q;
    assign framing_error = fe_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample. Before each frame is sent, the
// stimulus pushes the expected event onto a queue. A monitor pops and
// compares that event whenever data_valid or framing_error pulses.
// The receiver only counts os_clk periods, so the bench runs os_clk fast.
// That keeps every frame short in clk cycles. One bit is 16 os periods.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

    localparam int OS_HALF_NS = 85;
    localparam int OS_PER_NS  = 2 * OS_HALF_NS;
    localparam int BIT_NS     = 16 * OS_PER_NS;

    logic       clk    = 1'b0;
    logic       areset = 1'b1;
    logic       os_clk = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .areset        (areset),
        .os_clk        (os_clk),
        .rx            (rx),
        .data          (data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always #(OS_HALF_NS) os_clk = ~os_clk;

    typedef struct {
        bit         err;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] last_good   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!areset && (data_valid || framing_error)) begin
            vectors++;
            if (data_valid && framing_error) begin
                miscompares++;
                $display("FAIL both_pulses: data_valid=1 framing_error=1 required not both at %0t", $time);
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: dv=%0b fe=%0b data=%0h required no pulse at %0t",
                         data_valid, framing_error, data, $time);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.err !== framing_error || data !== mon_e.d) begin
                    miscompares++;
                    $display("FAIL event: fe=%0b data=%0h required fe=%0b data=%0h at %0t",
                             framing_error, data, mon_e.err, mon_e.d, $time);
                end
            end
        end
    end

    task automatic expect_byte(input logic [7:0] d);
        sb.push_back('{1'b0, d});
        last_good = d;
    endtask

    task automatic expect_ferr();
        sb.push_back('{1'b1, last_good});
    endtask

    // Start bit, 8 data bits LSB first, then the stop bit. The line is left
    // at the stop level so that a low stop bit can be extended into a break.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = stop;
        #(BIT_NS);
    endtask

    // Bounded wait for the monitor to consume every pending expectation.
    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, data, 8'h00);
        check({tag, "_dv"},   data_valid, 1'b0);
        check({tag, "_fe"},   framing_error, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // Watchdog so the run always ends even if the DUT hangs.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #100;
        @(negedge clk);
        check_reset_outputs("reset");
        areset = 1'b0;

        // Idle line for two bit times
        #(2 * BIT_NS);
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_data", data, 8'h00);

        // Single good frame
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1);
        drain("a5_drain");
        #(BIT_NS);
        @(negedge clk);
        check("a5_busy", busy, 1'b0);
        check("a5_data", data, 8'hA5);

        // Low glitches shorter than half a bit must be rejected
        rx = 1'b0;
        #(4 * OS_PER_NS);
        rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check("glitch4_busy", busy, 1'b0);
        check("glitch4_data", data, 8'hA5);
        rx = 1'b0;
        #(6 * OS_PER_NS);
        rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check("glitch6_busy", busy, 1'b0);
        check("glitch6_data", data, 8'hA5);

        // Framing error with the line held low afterwards
        expect_ferr();
        send_frame(8'h3C, 1'b0);
        #(3 * BIT_NS);
        drain("ferr_drain");
        @(negedge clk);
        check("break_busy", busy, 1'b1);
        check("break_data", data, 8'hA5);
        rx = 1'b1;
        #(OS_PER_NS + 100);
        @(negedge clk);
        check("break_exit_busy", busy, 1'b0);
        #(BIT_NS);

        // Back-to-back frames with no idle bit between them
        expect_byte(8'h00);
        expect_byte(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain("b2b_drain");
        @(negedge clk);
        check("b2b_data", data, 8'hFF);
        #(BIT_NS);

        // Reset in the middle of data bit 4, released with the line idle
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS / 2);
        areset = 1'b1;
        #50;
        @(negedge clk);
        check_reset_outputs("midreset");
        #50;
        areset = 1'b0;
        last_good = 8'h00;
        #(2 * BIT_NS);
        @(negedge clk);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_data", data, 8'h00);

        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1);
        drain("5a_drain");
        #(BIT_NS);
        @(negedge clk);
        check("5a_data", data, 8'h5A);
        check("5a_busy", busy, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
